// File: rtl/lock_dialer.sv
// Combination-entry driver for the up/down dial lock: dials CW to comb1,
// CCW to comb2, CW to comb3 one notch per cycle, mirroring the lock position.
module lock_dialer #(
  parameter int MSB = 5
) (
  input  logic         clock,
  input  logic         resetN,
  input  logic         start,
  input  logic         abort,
  input  logic [MSB:0] comb1,
  input  logic [MSB:0] comb2,
  input  logic [MSB:0] comb3,
  output logic         up,
  output logic         down,
  output logic         busy,
  output logic         done,
  output logic [MSB:0] position
);

  typedef enum logic [2:0] {IDLE, CW1, CCW2, CW3, DONE} state_t;

  state_t       state;
  state_t       nextState;
  logic [MSB:0] c1;
  logic [MSB:0] c2;
  logic [MSB:0] c3;
  logic [MSB:0] posInc;
  logic [MSB:0] posDec;
  logic         startAccept;

  assign posInc = position + 1'b1;
  assign posDec = position - 1'b1;

  // The step always lands before the compare, so a target equal to the
  // phase's start position costs a full revolution.
  always_comb begin
    nextState   = state;
    startAccept = 1'b0;
    up          = 1'b0;
    down        = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (!abort && start) begin
          nextState   = CW1;
          startAccept = 1'b1;
        end
      end
      CW1: begin
        up   = 1'b1;
        busy = 1'b1;
        if (abort)             nextState = IDLE;
        else if (posInc == c1) nextState = CCW2;
      end
      CCW2: begin
        down = 1'b1;
        busy = 1'b1;
        if (abort)             nextState = IDLE;
        else if (posDec == c2) nextState = CW3;
      end
      CW3: begin
        up   = 1'b1;
        busy = 1'b1;
        if (abort)             nextState = IDLE;
        else if (posInc == c3) nextState = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (abort) begin
          nextState = IDLE;
        end else if (start) begin
          nextState   = CW1;
          startAccept = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Position tracks the lock even on an aborting edge, since the lock moves too.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state    <= IDLE;
      position <= '0;
      c1       <= '0;
      c2       <= '0;
      c3       <= '0;
    end else begin
      state <= nextState;
      if (up)        position <= posInc;
      else if (down) position <= posDec;
      if (startAccept) begin
        c1 <= comb1;
        c2 <= comb2;
        c3 <= comb3;
      end
    end
  end

endmodule

// File: tb/tb_lock_dialer.sv
// Directed self-checking bench for lock_dialer: phase lengths, done timing,
// abort, mid-dial reset and ignored start/comb changes, against a lock model.
module tb_lock_dialer;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] comb1 = '0;
  logic [5:0] comb2 = '0;
  logic [5:0] comb3 = '0;
  logic       up;
  logic       down;
  logic       busy;
  logic       done;
  logic [5:0] position;

  logic [5:0] lockPos;
  int         checks = 0;
  int         errors = 0;
  int         violations = 0;
  int         n1, n2, n3, doneAt;

  lock_dialer #(.MSB(5)) dut (
    .clock(clock), .resetN(resetN), .start(start), .abort(abort),
    .comb1(comb1), .comb2(comb2), .comb3(comb3),
    .up(up), .down(down), .busy(busy), .done(done), .position(position)
  );

  always #5 clock = ~clock;

  // Model of the physical lock dial, driven by the dialer's outputs.
  always @(posedge clock) begin
    if (!resetN)   lockPos <= 6'd0;
    else if (up)   lockPos <= lockPos + 6'd1;
    else if (down) lockPos <= lockPos - 6'd1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyReset();
    resetN = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
  endtask

  task automatic applyStimulus(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    comb1 = a;
    comb2 = b;
    comb3 = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Starts a dial and measures the three phase lengths and the done cycle.
  // At cycle injectAt a spurious start with other combs is presented.
  task automatic runDial(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                         input int injectAt,
                         output int d1, output int d2, output int d3, output int dAt);
    logic sawDown;
    d1 = 0; d2 = 0; d3 = 0; dAt = -1; sawDown = 1'b0;
    applyStimulus(a, b, c);
    for (int cyc = 1; cyc <= 400 && dAt < 0; cyc++) begin
      if (up && !sawDown) d1++;
      else if (down) begin d2++; sawDown = 1'b1; end
      else if (up) d3++;
      if (up && down) violations++;
      if (busy !== (up | down)) violations++;
      if (busy && done) violations++;
      if (done) dAt = cyc;
      if (cyc == injectAt) begin
        start = 1'b1;
        comb1 = 6'd40; comb2 = 6'd5; comb3 = 6'd33;
      end else begin
        start = 1'b0;
      end
      if (dAt < 0) tick();
    end
    start = 1'b0;
  endtask

  initial begin
    // Reset with start held: must stay idle.
    start = 1'b1;
    applyReset();
    start = 1'b0;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_updown", {up, down}, 0);
    checkOutput("reset_position", position, 0);
    tick();
    checkOutput("idle_after_reset_busy", busy, 0);

    // Nominal 12/21/15 with a spurious start and comb change at cycle 20.
    runDial(6'd12, 6'd21, 6'd15, 20, n1, n2, n3, doneAt);
    checkOutput("nom_d1", n1, 12);
    checkOutput("nom_d2", n2, 55);
    checkOutput("nom_d3", n3, 58);
    checkOutput("nom_doneAt", doneAt, 126);
    checkOutput("nom_position", position, 15);
    checkOutput("nom_lockpos", position, lockPos);
    tick();
    checkOutput("nom_done_hold", done, 1);
    checkOutput("nom_done_still", {up, down}, 0);

    // Restart from DONE at position 15.
    runDial(6'd12, 6'd21, 6'd15, 0, n1, n2, n3, doneAt);
    checkOutput("redo_d1", n1, 61);
    checkOutput("redo_d2", n2, 55);
    checkOutput("redo_d3", n3, 58);
    checkOutput("redo_doneAt", doneAt, 175);
    checkOutput("redo_position", position, 15);

    // Abort in DONE returns to IDLE.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_done_done", done, 0);
    checkOutput("abort_done_busy", busy, 0);

    // comb1 equal to start position: full revolution in CW1.
    applyReset();
    runDial(6'd0, 6'd10, 6'd20, 0, n1, n2, n3, doneAt);
    checkOutput("rev1_d1", n1, 64);
    checkOutput("rev1_d2", n2, 54);
    checkOutput("rev1_d3", n3, 10);
    checkOutput("rev1_doneAt", doneAt, 129);
    checkOutput("rev1_position", position, 20);

    // comb2 == comb1: full revolution in CCW2.
    applyReset();
    runDial(6'd12, 6'd12, 6'd15, 0, n1, n2, n3, doneAt);
    checkOutput("rev2_d2", n2, 64);
    checkOutput("rev2_d3", n3, 3);
    checkOutput("rev2_doneAt", doneAt, 80);

    // comb3 == comb2: full revolution in CW3.
    applyReset();
    runDial(6'd12, 6'd21, 6'd21, 0, n1, n2, n3, doneAt);
    checkOutput("rev3_d3", n3, 64);
    checkOutput("rev3_doneAt", doneAt, 132);
    checkOutput("rev3_position", position, 21);

    // Abort during CCW2 at cycle 30; position keeps that cycle's step.
    applyReset();
    applyStimulus(6'd12, 6'd21, 6'd15);
    for (int i = 0; i < 29; i++) tick();
    checkOutput("abort_pre_down", down, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_updown", {up, down}, 0);
    checkOutput("abort_position", position, 58);
    checkOutput("abort_lockpos", position, lockPos);
    tick();
    runDial(6'd12, 6'd21, 6'd15, 0, n1, n2, n3, doneAt);
    checkOutput("abort_restart_d1", n1, 18);
    checkOutput("abort_restart_doneAt", doneAt, 132);
    checkOutput("abort_restart_position", position, 15);

    // Reset mid-CCW2 with start held.
    applyReset();
    applyStimulus(6'd12, 6'd21, 6'd15);
    for (int i = 0; i < 19; i++) tick();
    checkOutput("midreset_pre_down", down, 1);
    resetN = 1'b0;
    start = 1'b1;
    tick();
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_updown", {up, down}, 0);
    checkOutput("midreset_position", position, 0);
    tick();
    resetN = 1'b1;
    start = 1'b0;
    tick();
    checkOutput("midreset_idle", busy, 0);

    checkOutput("invariants", violations, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
